// File: rtl/mem_pkg.sv
// Shared types and helpers for the burst memory controller.
//   mem_state_t : controller state encoding (3 bits)
//   beat_addr   : wrapping-burst beat address, critical word first
//   DEF_*       : default parameter values
// Address widths up to 32 bits are supported by beat_addr.
package mem_pkg;

  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 22;
  localparam int DEF_BURST_LEN = 4;
  localparam int DEF_RD_LAT    = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    RD_BEAT = 3'd2,
    WR_BEAT = 3'd3,
    WR_DONE = 3'd4
  } mem_state_t;

  // Beat k stays inside the line-aligned block that holds base, so a burst
  // can never run off the end of memory.
  function automatic logic [31:0] beat_addr(input logic [31:0] base,
                                            input logic [31:0] k,
                                            input int          burst_len);
    logic [31:0] mask;
    mask = 32'(burst_len) - 32'd1;
    return (base & ~mask) | ((base + k) & mask);
  endfunction

endpackage

// File: rtl/burst_addr_gen.sv
// Beat address generator shared by the read and write paths.
//   clk, reset : clock, async active-high reset
//   load       : latch base_in and clear the beat counter
//   base_in    : word address of the critical beat
//   advance    : step to the next beat
//   addr       : address of the current beat
//   is_last    : current beat is beat BURST_LEN-1
module burst_addr_gen
  import mem_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] base_in,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              is_last
);

  localparam int CNT_W = $clog2(BURST_LEN);

  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      base_q <= base_in;
      cnt_q  <= '0;
    end else if (advance) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign addr    = ADDR_W'(beat_addr(32'(base_q), 32'(cnt_q), BURST_LEN));
  assign is_last = (cnt_q == CNT_W'(BURST_LEN - 1));

endmodule

// File: rtl/burst_mem_ctrl.sv
// Word-addressed main-memory model moving one cache line per request as
// BURST_LEN wrapping beats, with configurable read latency and byte strobes.
//   clk, reset           : clock, async active-high reset
//   req_valid/ready      : request handshake; req_addr = critical word,
//                          req_rw = 1 write, 0 read
//   wr_valid/ready       : write beat handshake with wr_data / wr_strb
//   rd_valid/ready       : read beat handshake with rd_data / rd_last
//   wr_done              : one-cycle pulse after the last write beat
//
// state   | meaning
// IDLE    | ready for a request (req_ready=1)
// RD_WAIT | counting down read latency
// RD_BEAT | presenting read beats on rd_*
// WR_BEAT | accepting write beats (wr_ready=1)
// WR_DONE | write burst complete, wr_done pulses
module burst_mem_ctrl
  import mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST_LEN = DEF_BURST_LEN,
  parameter int RD_LAT    = DEF_RD_LAT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic                req_rw,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_strb,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,
  output logic                wr_done
);

  localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STRB_W = DATA_W / 8;

  mem_state_t        state_q, state_d;
  logic [LAT_W-1:0]  lat_q;
  logic              gen_load, gen_adv, fetch, mem_we, rd_hs, lat_zero;
  logic [ADDR_W-1:0] addr;
  logic              is_last;

  logic [DATA_W-1:0] mem_q [2**ADDR_W];

  assign rd_hs    = rd_valid && rd_ready;
  assign lat_zero = (lat_q == '0);

  // The read path fetches one beat ahead of the consumer, so the generator
  // counter always points at the next beat to fetch; is_last at fetch time
  // therefore marks the beat being loaded into rd_data.
  burst_addr_gen #(
    .ADDR_W    (ADDR_W),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load    (gen_load),
    .base_in (req_addr),
    .advance (gen_adv),
    .addr    (addr),
    .is_last (is_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = req_rw ? WR_BEAT : RD_WAIT;
      RD_WAIT: if (lat_zero) state_d = RD_BEAT;
      RD_BEAT: if (rd_hs && rd_last) state_d = IDLE;
      WR_BEAT: if (wr_valid && is_last) state_d = WR_DONE;
      WR_DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    wr_ready  = 1'b0;
    fetch     = 1'b0;
    case (state_q)
      IDLE:    req_ready = 1'b1;
      RD_WAIT: fetch     = lat_zero;
      RD_BEAT: fetch     = rd_hs && !rd_last;
      WR_BEAT: wr_ready  = 1'b1;
      default: ;
    endcase
    gen_load = req_ready && req_valid;
    mem_we   = wr_ready && wr_valid;
    gen_adv  = fetch || mem_we;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_q    <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      wr_done  <= 1'b0;
    end else begin
      if (gen_load)
        lat_q <= LAT_W'(RD_LAT - 1);
      else if (state_q == RD_WAIT && !lat_zero)
        lat_q <= lat_q - LAT_W'(1);

      if (fetch) begin
        rd_valid <= 1'b1;
        rd_data  <= mem_q[addr];
        rd_last  <= is_last;
      end else if (rd_hs) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      wr_done <= (state_d == WR_DONE);
    end
  end

  // Array is deliberately outside reset: contents survive a mid-burst reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wr_strb[i]) mem_q[addr][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_burst_mem_ctrl.sv
// Randomized self-checking bench for burst_mem_ctrl against a word-array model.
module tb_burst_mem_ctrl;

  localparam int DW     = 32;
  localparam int AW     = 8;
  localparam int BL     = 4;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_rw;
  logic [AW-1:0] req_addr;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic [3:0]    wr_strb;
  logic          rd_valid, rd_ready, rd_last, wr_done;
  logic [DW-1:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;

  logic [DW-1:0] ref_mem [DEPTH];

  burst_mem_ctrl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .BURST_LEN (BL),
    .RD_LAT    (RD_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_rw    (req_rw),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .rd_valid  (rd_valid),
    .rd_ready  (rd_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .wr_done   (wr_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rd_valid && rd_ready) hs_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Beat k of a burst: same line as base, offset (base+k) mod BL.
  function automatic int model_addr(input int base, input int k);
    return (base / BL) * BL + (base + k) % BL;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_req_ready"}, 32'(req_ready), 1);
    check_val({tag, "_wr_ready"},  32'(wr_ready),  0);
    check_val({tag, "_rd_valid"},  32'(rd_valid),  0);
    check_val({tag, "_rd_data"},   rd_data,        0);
    check_val({tag, "_rd_last"},   32'(rd_last),   0);
    check_val({tag, "_wr_done"},   32'(wr_done),   0);
  endtask

  task automatic do_write(input int base, input logic [DW-1:0] d [BL],
                          input logic [3:0] s [BL], input bit gaps);
    int a;
    check_val("wr_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_addr = AW'(base); req_rw = 1'b1;
    tick();
    req_valid = 1'b0; req_rw = 1'b0;
    for (int k = 0; k < BL; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 1)) begin
          wr_valid = 1'b0; wr_data = $urandom; wr_strb = 4'hF;
          tick();
        end
      end
      check_val("wr_ready", 32'(wr_ready), 1);
      wr_valid = 1'b1; wr_data = d[k]; wr_strb = s[k];
      tick();
      a = model_addr(base, k);
      for (int i = 0; i < 4; i++)
        if (s[k][i]) ref_mem[a][8*i +: 8] = d[k][8*i +: 8];
    end
    wr_valid = 1'b0;
    check_val("wr_done_pulse", 32'(wr_done), 1);
    check_val("wr_busy_req_ready", 32'(req_ready), 0);
    tick();
    check_val("wr_done_clear", 32'(wr_done), 0);
    check_val("wr_idle_req_ready", 32'(req_ready), 1);
  endtask

  // stall_mode: 0 = rd_ready held high, 1 = random stalls, 2 = 3 stalls on beat 1
  task automatic do_read(input int base, input int stall_mode, input bit poke,
                         output logic [DW-1:0] got [BL]);
    int cnt;
    int n;
    logic [DW-1:0] exp;
    check_val("rd_req_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_addr = AW'(base); req_rw = 1'b0;
    tick();
    req_valid = 1'b0;
    cnt = 0;
    while (rd_valid !== 1'b1 && cnt < 20) begin
      if (poke) begin req_valid = 1'b1; req_rw = 1'b1; req_addr = AW'($urandom); end
      check_val("rd_wait_req_ready", 32'(req_ready), 0);
      tick();
      cnt++;
    end
    check_val("rd_latency", 32'(cnt), RD_LAT);
    for (int k = 0; k < BL; k++) begin
      exp = ref_mem[model_addr(base, k)];
      n = (stall_mode == 1) ? int'($urandom_range(0, 2)) :
          (stall_mode == 2 && k == 1) ? 3 : 0;
      repeat (n) begin
        rd_ready = 1'b0;
        if (poke) begin req_valid = 1'b1; req_rw = 1'b1; req_addr = AW'($urandom); end
        check_val("stall_rd_valid", 32'(rd_valid), 1);
        check_val("stall_rd_data", rd_data, exp);
        tick();
      end
      check_val("rd_valid", 32'(rd_valid), 1);
      check_val("rd_data", rd_data, exp);
      check_val("rd_last", 32'(rd_last), (k == BL - 1) ? 1 : 0);
      check_val("rd_busy_req_ready", 32'(req_ready), 0);
      got[k] = rd_data;
      rd_ready = 1'b1;
      tick();
    end
    rd_ready = 1'b0; req_valid = 1'b0; req_rw = 1'b0;
    check_val("rd_end_valid", 32'(rd_valid), 0);
    check_val("rd_end_req_ready", 32'(req_ready), 1);
  endtask

  initial begin
    logic [DW-1:0] d [BL];
    logic [3:0]    s [BL];
    logic [DW-1:0] got [BL];
    int            hs0;

    reset = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_rw = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_strb = '0; rd_ready = 1'b0;
    #23;
    check_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    tick();
    check_idle_outputs("post_reset");

    // Fill the whole array so every later read has a defined model value.
    for (int line = 0; line < DEPTH / BL; line++) begin
      for (int k = 0; k < BL; k++) begin d[k] = $urandom | 32'h1; s[k] = 4'hF; end
      do_write(line * BL + int'($urandom_range(0, BL - 1)), d, s, 1'b1);
    end

    // Write then read the same line, rd_ready held high.
    for (int k = 0; k < BL; k++) begin d[k] = 32'hA0 + 32'(k); s[k] = 4'hF; end
    do_write(32'h10, d, s, 1'b0);
    do_read(32'h10, 0, 1'b0, got);
    for (int k = 0; k < BL; k++) check_val("t1_data", got[k], 32'hA0 + 32'(k));

    // Wrapping burst: critical word first.
    d[0] = 32'h11; d[1] = 32'h22; d[2] = 32'h33; d[3] = 32'h44;
    do_write(32'h04, d, s, 1'b0);
    do_read(32'h06, 0, 1'b0, got);
    check_val("t2_b0", got[0], 32'h33);
    check_val("t2_b1", got[1], 32'h44);
    check_val("t2_b2", got[2], 32'h11);
    check_val("t2_b3", got[3], 32'h22);

    // Byte strobes on word 0x20.
    for (int k = 0; k < BL; k++) begin d[k] = 32'hFFFF_FFFF; s[k] = 4'hF; end
    do_write(32'h20, d, s, 1'b0);
    for (int k = 0; k < BL; k++) begin d[k] = 32'h1234_5678; s[k] = 4'h0; end
    s[0] = 4'b0101;
    do_write(32'h20, d, s, 1'b0);
    do_read(32'h20, 0, 1'b0, got);
    check_val("t3_strb", got[0], 32'hFF34_FF78);
    check_val("t3_keep", got[1], 32'hFFFF_FFFF);

    // Backpressure on beat 1, with ignored requests during the burst.
    hs0 = hs_cnt;
    do_read(32'h21, 2, 1'b1, got);
    check_val("t4_handshakes", 32'(hs_cnt - hs0), BL);
    do_read(32'h21, 0, 1'b0, got);

    // Reset during write beat 2 of a burst at 0x31.
    do_read(32'h30, 0, 1'b0, got);
    req_valid = 1'b1; req_addr = 8'h31; req_rw = 1'b1;
    tick();
    req_valid = 1'b0; req_rw = 1'b0;
    for (int k = 0; k < 2; k++) begin
      wr_valid = 1'b1; wr_data = 32'hB0 + 32'(k); wr_strb = 4'hF;
      tick();
      ref_mem[model_addr(32'h31, k)] = 32'hB0 + 32'(k);
    end
    wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF;
    #2 reset = 1'b1;
    #1 check_idle_outputs("midreset");
    @(posedge clk); #1;
    wr_valid = 1'b0; reset = 1'b0;
    tick();
    do_read(32'h31, 0, 1'b0, got);
    check_val("t5_beat0", got[0], 32'hB0);
    check_val("t5_beat1", got[1], 32'hB1);

    // Random mix of reads and writes, with stray wr_valid while idle.
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        wr_valid = 1'b1; wr_data = $urandom; wr_strb = 4'hF;
        tick();
        wr_valid = 1'b0;
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < BL; k++) begin d[k] = $urandom; s[k] = 4'($urandom); end
        do_write(int'($urandom_range(0, DEPTH - 1)), d, s, 1'b1);
      end else begin
        do_read(int'($urandom_range(0, DEPTH - 1)), 1, 1'($urandom), got);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
